// File: rtl/branch_predictor_f_pkg.sv
// ============================================================================
// branch_predictor_f_pkg
// Shared types for the fetch-stage branch predictor: counter states and reset state.
// Revision: 1.0
// ============================================================================
`default_nettype none

package branch_predictor_f_pkg;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } BpCounterState;

   localparam BpCounterState BP_RESET_STATE = WNT;

endpackage

`default_nettype wire

// File: rtl/branch_predictor_f_if.sv
// ============================================================================
// branch_predictor_f_if
// Fetch lookup, decode resolution and perf-counter signals of the predictor.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface branch_predictor_f_if #(
   parameter int PERF_W = 32
);
   logic [31:0]       iPCF;
   logic              oPredictTakenF;
   logic [31:0]       oPredictTargetF;
   logic              oHitF;
   logic              iResolveValidD;
   logic [31:0]       iResolvePCD;
   logic [31:0]       iResolveTargetD;
   logic              iActualTakenD;
   logic              iMispredictD;
   logic              iFlushTable;
   logic [PERF_W-1:0] oBranchCount;
   logic [PERF_W-1:0] oMispredictCount;

   modport master (
      output iPCF, iResolveValidD, iResolvePCD, iResolveTargetD,
             iActualTakenD, iMispredictD, iFlushTable,
      input  oPredictTakenF, oPredictTargetF, oHitF, oBranchCount, oMispredictCount
   );

   modport slave (
      input  iPCF, iResolveValidD, iResolvePCD, iResolveTargetD,
             iActualTakenD, iMispredictD, iFlushTable,
      output oPredictTakenF, oPredictTargetF, oHitF, oBranchCount, oMispredictCount
   );
endinterface

`default_nettype wire

// File: rtl/branch_predictor_f_sat_counter2.sv
// ============================================================================
// sat_counter2
// Next-state logic for one 2-bit saturating taken/not-taken counter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sat_counter2
   import branch_predictor_f_pkg::*;
(
   input  BpCounterState i_state,
   input  logic          i_taken,
   output BpCounterState o_next
);

   always_comb begin
      o_next = i_state;
      unique case (i_state)
         SNT: o_next = i_taken ? WNT : SNT;
         WNT: o_next = i_taken ? WT  : SNT;
         WT:  o_next = i_taken ? ST  : WNT;
         ST:  o_next = i_taken ? ST  : WT;
         default: o_next = i_state;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/branch_predictor_f.sv
// ============================================================================
// branch_predictor_f
// Direct-mapped BTB with 2-bit counters, learning from decode resolution.
// Revision: 1.0
// ============================================================================
`default_nettype none

module branch_predictor_f
   import branch_predictor_f_pkg::*;
#(
   parameter int ENTRIES = 16,
   parameter int TAG_W   = 8,
   parameter int PERF_W  = 32
) (
   input  wire                    iClk,
   input  wire                    iRstN,
   branch_predictor_f_if.slave    bp
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_LO = IDX_W + 2;
   localparam int TAG_HI = IDX_W + TAG_W + 1;

   logic [ENTRIES-1:0] r_valid;
   logic [TAG_W-1:0]   r_tag    [ENTRIES];
   logic [31:0]        r_target [ENTRIES];
   BpCounterState      r_ctr    [ENTRIES];
   logic [PERF_W-1:0]  r_br_cnt;
   logic [PERF_W-1:0]  r_mp_cnt;

   logic [IDX_W-1:0]   w_lk_idx;
   logic [TAG_W-1:0]   w_lk_tag;
   logic               w_lk_hit;
   logic [IDX_W-1:0]   w_up_idx;
   logic [TAG_W-1:0]   w_up_tag;
   logic               w_up_hit;
   BpCounterState      w_ctr_next;
   logic               w_unused_pc_bits;

   assign w_lk_idx = bp.iPCF[IDX_W+1:2];
   assign w_lk_tag = bp.iPCF[TAG_HI:TAG_LO];
   assign w_lk_hit = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);

   assign bp.oHitF           = w_lk_hit;
   assign bp.oPredictTakenF  = w_lk_hit && r_ctr[w_lk_idx][1];
   assign bp.oPredictTargetF = (w_lk_hit && r_ctr[w_lk_idx][1]) ? r_target[w_lk_idx] : 32'h0;

   assign w_up_idx = bp.iResolvePCD[IDX_W+1:2];
   assign w_up_tag = bp.iResolvePCD[TAG_HI:TAG_LO];
   assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);

   // Single counter stepper shared by all entries; only the resolving entry moves.
   sat_counter2 u_sat_counter2 (
      .i_state (r_ctr[w_up_idx]),
      .i_taken (bp.iActualTakenD),
      .o_next  (w_ctr_next)
   );

   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         r_valid <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            r_tag[i]    <= '0;
            r_target[i] <= '0;
            r_ctr[i]    <= BP_RESET_STATE;
         end
      end else if (bp.iFlushTable) begin
         r_valid <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            r_ctr[i] <= BP_RESET_STATE;
         end
      end else if (bp.iResolveValidD) begin
         if (w_up_hit) begin
            r_ctr[w_up_idx] <= w_ctr_next;
            if (bp.iActualTakenD) begin
               r_target[w_up_idx] <= bp.iResolveTargetD;
            end
         end else if (bp.iActualTakenD) begin
            r_valid[w_up_idx]  <= 1'b1;
            r_tag[w_up_idx]    <= w_up_tag;
            r_target[w_up_idx] <= bp.iResolveTargetD;
            r_ctr[w_up_idx]    <= WT;
         end
      end
   end

   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         r_br_cnt <= '0;
         r_mp_cnt <= '0;
      end else if (bp.iResolveValidD) begin
         if (!(&r_br_cnt)) begin
            r_br_cnt <= r_br_cnt + 1'b1;
         end
         if (bp.iMispredictD && !(&r_mp_cnt)) begin
            r_mp_cnt <= r_mp_cnt + 1'b1;
         end
      end
   end

   assign bp.oBranchCount     = r_br_cnt;
   assign bp.oMispredictCount = r_mp_cnt;

   // Byte-offset and above-tag PC bits take no part in indexing or matching.
   assign w_unused_pc_bits = ^{bp.iPCF[1:0], bp.iPCF[31:TAG_HI+1],
                               bp.iResolvePCD[1:0], bp.iResolvePCD[31:TAG_HI+1]};

endmodule

`default_nettype wire

// File: tb/tb_branch_predictor_f.sv
// ============================================================================
// tb_branch_predictor_f
// Directed vector bench for branch_predictor_f (ENTRIES=16, TAG_W=8, PERF_W=6).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_branch_predictor_f;
   import branch_predictor_f_pkg::*;

   localparam int PW = 6;
   localparam int PMAX = (1 << PW) - 1;

   logic clk;
   logic rst_n;
   int   nchk;
   int   nfail;
   int   exp_br;
   int   exp_mp;

   branch_predictor_f_if #(.PERF_W(PW)) bp ();

   branch_predictor_f #(.ENTRIES(16), .TAG_W(8), .PERF_W(PW)) dut (
      .iClk  (clk),
      .iRstN (rst_n),
      .bp    (bp.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        rv;
      logic [31:0] rpc;
      logic [31:0] rtgt;
      logic        tk;
      logic        mis;
      logic        fl;
      logic [31:0] lpc;
      logic        e_hit;
      logic        e_tk;
      logic [31:0] e_tgt;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic check_lookup(input string name, input logic e_hit, input logic e_tk,
                               input logic [31:0] e_tgt);
      check({name, " hit"}, {31'd0, bp.oHitF}, {31'd0, e_hit});
      check({name, " taken"}, {31'd0, bp.oPredictTakenF}, {31'd0, e_tk});
      check({name, " target"}, bp.oPredictTargetF, e_tgt);
   endtask

   task automatic check_perf(input string name);
      check({name, " brcnt"}, {{(32-PW){1'b0}}, bp.oBranchCount}, exp_br);
      check({name, " mpcnt"}, {{(32-PW){1'b0}}, bp.oMispredictCount}, exp_mp);
   endtask

   // One resolve cycle; lookup PC is held across the edge and checked afterwards.
   task automatic cycle(input logic rv, input logic [31:0] rpc, input logic [31:0] rtgt,
                        input logic tk, input logic mis, input logic fl,
                        input logic [31:0] lpc);
      @(negedge clk);
      bp.iResolveValidD  = rv;
      bp.iResolvePCD     = rpc;
      bp.iResolveTargetD = rtgt;
      bp.iActualTakenD   = tk;
      bp.iMispredictD    = mis;
      bp.iFlushTable     = fl;
      bp.iPCF            = lpc;
      @(posedge clk);
      #1;
      bp.iResolveValidD = 1'b0;
      bp.iFlushTable    = 1'b0;
      if (rv) begin
         if (exp_br < PMAX) exp_br++;
         if (mis && exp_mp < PMAX) exp_mp++;
      end
      #1;
   endtask

   initial begin
      nchk = 0; nfail = 0; exp_br = 0; exp_mp = 0;
      rst_n = 1'b0;
      bp.iPCF = 32'h100; bp.iResolveValidD = 1'b0; bp.iResolvePCD = '0;
      bp.iResolveTargetD = '0; bp.iActualTakenD = 1'b0; bp.iMispredictD = 1'b0;
      bp.iFlushTable = 1'b0;

      // 0x100 -> idx 0 tag 4; 0x140 -> idx 0 tag 5; 0x4140 aliases 0x140 above the tag.
      vecs.push_back('{"reset",        0, 32'h000, 32'h000, 0, 0, 0, 32'h100,  0, 0, 32'h0});
      vecs.push_back('{"alloc_wt",     1, 32'h100, 32'h080, 1, 1, 0, 32'h100,  1, 1, 32'h80});
      vecs.push_back('{"wt_to_wnt",    1, 32'h100, 32'h000, 0, 1, 0, 32'h100,  1, 0, 32'h0});
      vecs.push_back('{"wnt_to_snt",   1, 32'h100, 32'h000, 0, 0, 0, 32'h100,  1, 0, 32'h0});
      vecs.push_back('{"snt_hold",     1, 32'h100, 32'h000, 0, 0, 0, 32'h100,  1, 0, 32'h0});
      vecs.push_back('{"snt_to_wnt",   1, 32'h100, 32'h090, 1, 1, 0, 32'h100,  1, 0, 32'h0});
      vecs.push_back('{"wnt_to_wt",    1, 32'h100, 32'h090, 1, 1, 0, 32'h100,  1, 1, 32'h90});
      vecs.push_back('{"wt_to_st",     1, 32'h100, 32'h0A0, 1, 0, 0, 32'h100,  1, 1, 32'hA0});
      vecs.push_back('{"st_hold",      1, 32'h100, 32'h0A0, 1, 0, 0, 32'h100,  1, 1, 32'hA0});
      vecs.push_back('{"st_nt_keeptg", 1, 32'h100, 32'h0F0, 0, 1, 0, 32'h100,  1, 1, 32'hA0});
      vecs.push_back('{"replace_old",  1, 32'h140, 32'h200, 1, 1, 0, 32'h100,  0, 0, 32'h0});
      vecs.push_back('{"replace_new",  0, 32'h000, 32'h000, 0, 0, 0, 32'h140,  1, 1, 32'h200});
      vecs.push_back('{"miss_nt_noal", 1, 32'h144, 32'h300, 0, 1, 0, 32'h144,  0, 0, 32'h0});
      vecs.push_back('{"other_idx",    1, 32'h104, 32'h000, 0, 0, 0, 32'h140,  1, 1, 32'h200});
      vecs.push_back('{"alias_high",   0, 32'h000, 32'h000, 0, 0, 0, 32'h4140, 1, 1, 32'h200});
      vecs.push_back('{"flush",        0, 32'h000, 32'h000, 0, 0, 1, 32'h140,  0, 0, 32'h0});
      vecs.push_back('{"realloc",      1, 32'h140, 32'h300, 1, 0, 0, 32'h140,  1, 1, 32'h300});

      repeat (2) @(posedge clk);
      #2;
      check_lookup("reset_state", 1'b0, 1'b0, 32'h0);
      check_perf("reset_state");
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         cycle(vecs[i].rv, vecs[i].rpc, vecs[i].rtgt, vecs[i].tk, vecs[i].mis,
               vecs[i].fl, vecs[i].lpc);
         check_lookup(vecs[i].name, vecs[i].e_hit, vecs[i].e_tk, vecs[i].e_tgt);
         check_perf(vecs[i].name);
      end

      // Same-cycle update and lookup of one index: lookup sees pre-update state.
      @(negedge clk);
      bp.iPCF = 32'h140; bp.iResolvePCD = 32'h140; bp.iResolveTargetD = 32'h0;
      bp.iActualTakenD = 1'b0; bp.iMispredictD = 1'b1; bp.iResolveValidD = 1'b1;
      #1;
      check_lookup("same_cycle_pre", 1'b1, 1'b1, 32'h300);
      @(posedge clk);
      #1;
      bp.iResolveValidD = 1'b0;
      exp_br++; exp_mp++;
      #1;
      check_lookup("same_cycle_post", 1'b1, 1'b0, 32'h0);

      // Flush wins over a simultaneous allocating update; perf still counts it.
      cycle(1'b1, 32'h180, 32'h400, 1'b1, 1'b1, 1'b1, 32'h180);
      check_lookup("flush_upd_new", 1'b0, 1'b0, 32'h0);
      check_perf("flush_upd");
      cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h140);
      check_lookup("flush_upd_old", 1'b0, 1'b0, 32'h0);

      // Drive both perf counters into saturation with non-allocating resolves.
      for (int k = 0; k < 2 * PMAX && (exp_br < PMAX || exp_mp < PMAX); k++) begin
         cycle(1'b1, 32'h200, 32'h0, 1'b0, 1'b1, 1'b0, 32'h200);
      end
      check_perf("sat_reached");
      cycle(1'b1, 32'h200, 32'h0, 1'b0, 1'b1, 1'b0, 32'h200);
      check_perf("sat_hold_mis");
      cycle(1'b1, 32'h200, 32'h0, 1'b0, 1'b0, 1'b0, 32'h200);
      check_perf("sat_hold_nomis");

      // Async reset during an in-flight allocating update discards it.
      cycle(1'b1, 32'h1C0, 32'h500, 1'b1, 1'b0, 1'b0, 32'h1C0);
      check_lookup("pre_rst_alloc", 1'b1, 1'b1, 32'h500);
      @(negedge clk);
      bp.iResolvePCD = 32'h140; bp.iResolveTargetD = 32'h600;
      bp.iActualTakenD = 1'b1; bp.iMispredictD = 1'b1; bp.iResolveValidD = 1'b1;
      #2;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      bp.iResolveValidD = 1'b0;
      exp_br = 0; exp_mp = 0;
      @(negedge clk);
      rst_n = 1'b1;
      bp.iPCF = 32'h1C0;
      #1;
      check_lookup("rst_mid_1c0", 1'b0, 1'b0, 32'h0);
      bp.iPCF = 32'h140;
      #1;
      check_lookup("rst_mid_140", 1'b0, 1'b0, 32'h0);
      check_perf("rst_mid");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
      $finish;
   end

endmodule

`default_nettype wire
